// File: rtl/operand_source.sv
// Operand producer for the multiplier: captures A then B from the switches on enter presses
// and hands the pair to the control unit. Optional enter debounce under OPERAND_DEBOUNCE_EN.
module operand_source #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             enter,
  input  logic             loaddata,
  output logic             inputdata_ready,
  output logic [WIDTH-1:0] dataA,
  output logic [WIDTH-1:0] dataB,
  output logic [1:0]       phase
);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    READY  = 2'b10
  } state_t;

  state_t state;
  logic   s1, s2, prev;
  logic   level;
  logic   press;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("operand_source: DEBOUNCE_CYCLES must be at least 1");
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= enter;
      s2   <= s1;
      prev <= level;
    end
  end

`ifdef OPERAND_DEBOUNCE_EN
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Count saturates at CNT_MAX so a long hold keeps the level high without wrapping.
  always_ff @(posedge clk) begin
    if (reset || !s2) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = s2 && (cnt == CNT_MAX);
`else
  assign level = s2;
`endif

  assign press = level & ~prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_A;
      dataA <= '0;
      dataB <= '0;
    end else begin
      case (state)
        WAIT_A: begin
          if (press) begin
            dataA <= sw_data;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (press) begin
            dataB <= sw_data;
            state <= READY;
          end
        end
        // A press in READY is swallowed; loaddata alone decides the exit.
        READY: begin
          if (loaddata) begin
            state <= WAIT_A;
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

  assign inputdata_ready = (state == READY);
  assign phase           = state;

endmodule

// File: tb/tb_operand_source.sv
// Directed bench for operand_source: expected operand pairs go into a scoreboard queue and a
// monitor compares them each time inputdata_ready rises; state/phase checks are made inline.
module tb_operand_source;

  localparam int WIDTH = 8;
`ifdef OPERAND_DEBOUNCE_EN
  localparam int DLY = 16;
`else
  localparam int DLY = 0;
`endif
  // Negedges from raising enter until the press has been captured.
  localparam int LAT  = 3 + DLY;
  localparam int HOLD = 4 + DLY;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] sw_data;
  logic             enter;
  logic             loaddata;
  logic             inputdata_ready;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [1:0]       phase;

  int vectors     = 0;
  int miscompares = 0;

  logic [2*WIDTH-1:0] exp_q[$];
  logic               ready_q = 1'b0;

  operand_source #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .sw_data        (sw_data),
    .enter          (enter),
    .loaddata       (loaddata),
    .inputdata_ready(inputdata_ready),
    .dataA          (dataA),
    .dataB          (dataB),
    .phase          (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [WIDTH-1:0] v, input int hold);
    sw_data = v;
    enter   = 1'b1;
    cyc(hold);
    enter   = 1'b0;
    cyc(4);
  endtask

  // Scoreboard monitor: every rising edge of inputdata_ready must deliver the next expected pair.
  always @(negedge clk) begin
    if (inputdata_ready === 1'b1 && ready_q == 1'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected_ready: got pair 0x%0h, want no handoff at %0t",
                 {dataA, dataB}, $time);
      end else begin
        check("sb_pair", 32'({dataA, dataB}), 32'(exp_q.pop_front()));
      end
    end
    ready_q = (inputdata_ready === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    enter    = 1'b1;
    loaddata = 1'b1;
    sw_data  = 8'hFF;

    // T1: reset with enter and loaddata asserted
    cyc(2);
    check("t1_ready", 32'(inputdata_ready), 0);
    check("t1_dataA", 32'(dataA), 0);
    check("t1_dataB", 32'(dataB), 0);
    check("t1_phase", 32'(phase), 0);
    reset    = 1'b0;
    enter    = 1'b0;
    loaddata = 1'b0;
    cyc(4);
    check("t1_idle_phase", 32'(phase), 0);

    // T2: nominal capture and press-to-ready latency
    pulse(8'h3C, HOLD);
    check("t2_phase_waitb", 32'(phase), 1);
    check("t2_dataA", 32'(dataA), 32'h3C);
    exp_q.push_back({8'h3C, 8'h05});
    sw_data = 8'h05;
    enter   = 1'b1;
    cyc(LAT - 1);
    check("t2_ready_early", 32'(inputdata_ready), 0);
    cyc(1);
    check("t2_ready", 32'(inputdata_ready), 1);
    check("t2_phase_ready", 32'(phase), 2);
    enter = 1'b0;
    cyc(4);

    // T3: ready held while loaddata low, dropped after one loaddata cycle
    for (int i = 0; i < 10; i++) begin
      check("t3_ready_hold", 32'(inputdata_ready), 1);
      cyc(1);
    end
    loaddata = 1'b1;
    cyc(1);
    loaddata = 1'b0;
    check("t3_ready_drop", 32'(inputdata_ready), 0);
    check("t3_phase", 32'(phase), 0);
    check("t3_data_held", 32'({dataA, dataB}), 32'h3C05);

    // T4: enter held 50 cycles gives one capture; extra presses in READY are ignored
    sw_data = 8'h11;
    enter   = 1'b1;
    cyc(25);
    check("t4_phase_held", 32'(phase), 1);
    check("t4_dataA_held", 32'(dataA), 32'h11);
    sw_data = 8'h22;
    cyc(25);
    check("t4_single_capture_phase", 32'(phase), 1);
    check("t4_single_capture_dataA", 32'(dataA), 32'h11);
    enter = 1'b0;
    cyc(4);
    exp_q.push_back({8'h11, 8'h33});
    pulse(8'h33, HOLD);
    check("t4_phase_ready", 32'(phase), 2);
    pulse(8'h44, HOLD);
    pulse(8'h55, HOLD);
    pulse(8'h66, HOLD);
    check("t4_extra_phase", 32'(phase), 2);
    check("t4_extra_data", 32'({dataA, dataB}), 32'h1133);
    loaddata = 1'b1;
    cyc(1);
    loaddata = 1'b0;
    check("t4_handoff_phase", 32'(phase), 0);

    // T5: press coinciding with loaddata is dropped; then reset in WAIT_B
    exp_q.push_back({8'hA5, 8'h5A});
    pulse(8'hA5, HOLD);
    pulse(8'h5A, HOLD);
    check("t5_ready", 32'(inputdata_ready), 1);
    sw_data = 8'h77;
    enter   = 1'b1;
    cyc(LAT - 1);
    loaddata = 1'b1;
    cyc(1);
    loaddata = 1'b0;
    check("t5_collision_phase", 32'(phase), 0);
    check("t5_collision_data", 32'({dataA, dataB}), 32'hA55A);
    enter = 1'b0;
    cyc(4);
    check("t5_press_not_queued", 32'(phase), 0);
    pulse(8'h99, HOLD);
    check("t5_waitb_phase", 32'(phase), 1);
    check("t5_waitb_dataA", 32'(dataA), 32'h99);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("t5_reset_dataA", 32'(dataA), 0);
    check("t5_reset_dataB", 32'(dataB), 0);
    check("t5_reset_phase", 32'(phase), 0);
    check("t5_reset_ready", 32'(inputdata_ready), 0);
    cyc(2);

`ifdef OPERAND_DEBOUNCE_EN
    // T6: short glitch rejected; long press captured 16 cycles after the undebounced timing
    sw_data = 8'h42;
    enter   = 1'b1;
    cyc(5);
    enter = 1'b0;
    cyc(25);
    check("t6_glitch_phase", 32'(phase), 0);
    check("t6_glitch_dataA", 32'(dataA), 0);
    enter = 1'b1;
    cyc(LAT - 1);
    check("t6_not_yet", 32'(phase), 0);
    cyc(1);
    check("t6_capture_phase", 32'(phase), 1);
    check("t6_capture_dataA", 32'(dataA), 32'h42);
    cyc(1);
    enter = 1'b0;
    cyc(4);
`endif

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
